// File: rtl/matmul_apb_slave.sv
// matmul_apb_slave: APB slave front-end of the matmul accelerator.
// Decodes CONTROL/OPERAND/FLAGS/SP regions and drives the compute core.
module matmul_apb_slave #(
  parameter int DATA_WIDTH  = 8,
  parameter int BUS_WIDTH   = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int SP_NTARGETS = 4,
  localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH,
  localparam int IW = $clog2(MAX_DIM),
  localparam int TW = $clog2(SP_NTARGETS)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic                  pwrite_i,
  input  logic [MAX_DIM-1:0]    pstrb_i,
  input  logic [ADDR_WIDTH-1:0] paddr_i,
  input  logic [BUS_WIDTH-1:0]  pwdata_i,
  output logic [BUS_WIDTH-1:0]  prdata_o,
  output logic                  pready_o,
  output logic                  pslverr_o,
  output logic                  busy_o,
  output logic                  start_o,
  output logic [BUS_WIDTH-1:0]  ctrl_o,
  output logic                  op_a_we_o,
  output logic                  op_b_we_o,
  output logic [IW-1:0]         op_idx_o,
  output logic [BUS_WIDTH-1:0]  op_wdata_o,
  output logic [MAX_DIM-1:0]    op_strb_o,
  output logic                  sp_re_o,
  output logic [TW+IW-1:0]      sp_addr_o,
  input  logic [BUS_WIDTH-1:0]  sp_rdata_i,
  input  logic                  done_i,
  input  logic [BUS_WIDTH-1:0]  flags_i
);

  localparam logic [4:0] R_CTRL  = 5'h00;
  localparam logic [4:0] R_OPA   = 5'h04;
  localparam logic [4:0] R_OPB   = 5'h08;
  localparam logic [4:0] R_FLAGS = 5'h0C;
  localparam logic [4:0] R_SP    = 5'h10;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    SP_WAIT
  } state_e;

  state_e state_q, state_d;

  logic [BUS_WIDTH-1:0] ctrl_q, ctrl_d;
  logic [BUS_WIDTH-1:0] flags_q, flags_d;
  logic                 busy_q, busy_d;
  logic                 start_q, start_d;
  logic                 opa_we_q, opa_we_d;
  logic                 opb_we_q, opb_we_d;
  logic [IW-1:0]        op_idx_q, op_idx_d;
  logic [BUS_WIDTH-1:0] op_wdata_q, op_wdata_d;
  logic [MAX_DIM-1:0]   op_strb_q, op_strb_d;

  logic          is_ctrl, is_opa, is_opb;
  logic          is_flags, is_sp;
  logic          acc_err, wr_ok;
  logic [IW-1:0] idx;
  logic          unused_addr;

  assign is_ctrl  = (paddr_i[4:0] == R_CTRL);
  assign is_opa   = (paddr_i[4:0] == R_OPA);
  assign is_opb   = (paddr_i[4:0] == R_OPB);
  assign is_flags = (paddr_i[4:0] == R_FLAGS);
  assign is_sp    = (paddr_i[4:0] == R_SP);
  assign idx      = paddr_i[5 +: IW];

  assign unused_addr = ^paddr_i[ADDR_WIDTH-1:5+IW];

  always_comb begin
    acc_err = 1'b0;
    if (|paddr_i[1:0])
      acc_err = 1'b1;
    if (!(is_ctrl | is_opa | is_opb | is_flags | is_sp))
      acc_err = 1'b1;
    if (pwrite_i & (is_flags | is_sp))
      acc_err = 1'b1;
    if (!pwrite_i & (is_opa | is_opb))
      acc_err = 1'b1;
    if (pwrite_i & busy_q & (is_ctrl | is_opa | is_opb))
      acc_err = 1'b1;
  end

  // Only a legal SP read takes a wait state; the SP
  // memory answers one cycle after sp_re_o.
  always_comb begin
    state_d   = state_q;
    pready_o  = 1'b0;
    pslverr_o = 1'b0;
    prdata_o  = '0;
    sp_re_o   = 1'b0;
    wr_ok     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (psel_i & !penable_i)
          state_d = ACCESS;
      end
      ACCESS: begin
        if (!psel_i) begin
          state_d = IDLE;
        end else if (penable_i) begin
          if (!acc_err & !pwrite_i & is_sp) begin
            sp_re_o = 1'b1;
            state_d = SP_WAIT;
          end else begin
            pready_o  = 1'b1;
            pslverr_o = acc_err;
            wr_ok     = pwrite_i & !acc_err;
            state_d   = IDLE;
            if (!pwrite_i & !acc_err)
              prdata_o = is_ctrl ? ctrl_q : flags_q;
          end
        end
      end
      SP_WAIT: begin
        state_d = IDLE;
        if (psel_i) begin
          pready_o = 1'b1;
          prdata_o = sp_rdata_i;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ctrl_d = ctrl_q;
    if (wr_ok & is_ctrl) begin
      for (int e = 0; e < MAX_DIM; e++) begin
        if (pstrb_i[e])
          ctrl_d[e*DATA_WIDTH +: DATA_WIDTH] =
            pwdata_i[e*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    ctrl_d[0] = 1'b0;
    start_d = wr_ok & is_ctrl & pstrb_i[0] & pwdata_i[0];
    // A new run started in the done cycle keeps busy set.
    busy_d  = start_d ? 1'b1 : (done_i ? 1'b0 : busy_q);
    flags_d = done_i ? flags_i : flags_q;
    opa_we_d   = wr_ok & is_opa & (|pstrb_i);
    opb_we_d   = wr_ok & is_opb & (|pstrb_i);
    op_idx_d   = op_idx_q;
    op_wdata_d = op_wdata_q;
    op_strb_d  = op_strb_q;
    if (wr_ok & (is_opa | is_opb)) begin
      op_idx_d   = idx;
      op_wdata_d = pwdata_i;
      op_strb_d  = pstrb_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      ctrl_q     <= '0;
      flags_q    <= '0;
      busy_q     <= 1'b0;
      start_q    <= 1'b0;
      opa_we_q   <= 1'b0;
      opb_we_q   <= 1'b0;
      op_idx_q   <= '0;
      op_wdata_q <= '0;
      op_strb_q  <= '0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      flags_q    <= flags_d;
      busy_q     <= busy_d;
      start_q    <= start_d;
      opa_we_q   <= opa_we_d;
      opb_we_q   <= opb_we_d;
      op_idx_q   <= op_idx_d;
      op_wdata_q <= op_wdata_d;
      op_strb_q  <= op_strb_d;
    end
  end

  assign sp_addr_o  = sp_re_o ? {ctrl_q[4 +: TW], idx} : '0;
  assign ctrl_o     = ctrl_q;
  assign busy_o     = busy_q;
  assign start_o    = start_q;
  assign op_a_we_o  = opa_we_q;
  assign op_b_we_o  = opb_we_q;
  assign op_idx_o   = op_idx_q;
  assign op_wdata_o = op_wdata_q;
  assign op_strb_o  = op_strb_q;

endmodule

// File: tb/tb_matmul_apb_slave.sv
// tb_matmul_apb_slave: scoreboard bench for the matmul APB slave.
// A reference model predicts responses; monitors compare DUT outputs.
module tb_matmul_apb_slave;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        psel_i, penable_i, pwrite_i;
  logic [3:0]  pstrb_i;
  logic [31:0] paddr_i, pwdata_i;
  logic [31:0] prdata_o;
  logic        pready_o, pslverr_o, busy_o, start_o;
  logic [31:0] ctrl_o;
  logic        op_a_we_o, op_b_we_o;
  logic [1:0]  op_idx_o;
  logic [31:0] op_wdata_o;
  logic [3:0]  op_strb_o;
  logic        sp_re_o;
  logic [3:0]  sp_addr_o;
  logic [31:0] sp_rdata_i;
  logic        done_i;
  logic [31:0] flags_i;

  always #5 clk = ~clk;

  matmul_apb_slave dut (
    .clk_i(clk), .rst_i(rst_i),
    .psel_i(psel_i), .penable_i(penable_i),
    .pwrite_i(pwrite_i), .pstrb_i(pstrb_i),
    .paddr_i(paddr_i), .pwdata_i(pwdata_i),
    .prdata_o(prdata_o), .pready_o(pready_o),
    .pslverr_o(pslverr_o), .busy_o(busy_o),
    .start_o(start_o), .ctrl_o(ctrl_o),
    .op_a_we_o(op_a_we_o), .op_b_we_o(op_b_we_o),
    .op_idx_o(op_idx_o), .op_wdata_o(op_wdata_o),
    .op_strb_o(op_strb_o), .sp_re_o(sp_re_o),
    .sp_addr_o(sp_addr_o), .sp_rdata_i(sp_rdata_i),
    .done_i(done_i), .flags_i(flags_i)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        w;
    logic        err;
    logic [31:0] rd;
  } rsp_t;

  typedef struct {
    logic        b;
    logic [1:0]  idx;
    logic [31:0] d;
    logic [3:0]  s;
  } op_t;

  rsp_t       rsp_q[$];
  op_t        op_q[$];
  logic [3:0] sp_q[$];
  int         start_q[$];

  logic [31:0] ctrl_m, flags_m;
  logic        busy_m;
  logic [31:0] sp_mem [16];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic miss(input string nm);
    checks++;
    errors++;
    $display("FAIL %s actual=none expected=one", nm);
  endtask

  // scratchpad memory stand-in: data one cycle after sp_re_o
  always @(posedge clk)
    sp_rdata_i <= sp_re_o ? sp_mem[sp_addr_o] : $urandom;

  always @(negedge clk) begin
    if (!rst_i) begin
      if (pready_o) begin
        if (rsp_q.size() == 0) miss("pready_expected");
        else begin
          rsp_t r;
          r = rsp_q.pop_front();
          chk("pslverr", {31'd0, pslverr_o}, {31'd0, r.err});
          if (!r.w && !r.err) chk("prdata", prdata_o, r.rd);
        end
      end
      if (sp_re_o) begin
        if (sp_q.size() == 0) miss("sp_re_expected");
        else chk("sp_addr", {28'd0, sp_addr_o}, {28'd0, sp_q.pop_front()});
      end
      if (op_a_we_o || op_b_we_o) begin
        if (op_q.size() == 0) miss("op_we_expected");
        else begin
          op_t o;
          o = op_q.pop_front();
          chk("op_b_we", {31'd0, op_b_we_o}, {31'd0, o.b});
          chk("op_a_we", {31'd0, op_a_we_o}, {31'd0, !o.b});
          chk("op_idx", {30'd0, op_idx_o}, {30'd0, o.idx});
          chk("op_wdata", op_wdata_o, o.d);
          chk("op_strb", {28'd0, op_strb_o}, {28'd0, o.s});
        end
      end
      if (start_o) begin
        if (start_q.size() == 0) miss("start_expected");
        else begin
          checks++;
          void'(start_q.pop_front());
        end
      end
    end
  end

  task automatic model_reset();
    ctrl_m  = 0;
    flags_m = 0;
    busy_m  = 0;
    rsp_q.delete();
    op_q.delete();
    sp_q.delete();
    start_q.delete();
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, "_ctrl"}, ctrl_o, 0);
    chk({nm, "_prdata"}, prdata_o, 0);
    chk({nm, "_op_wdata"}, op_wdata_o, 0);
    chk({nm, "_bits"},
        {25'd0, pready_o, pslverr_o, busy_o, start_o,
         op_a_we_o, op_b_we_o, sp_re_o}, 0);
    chk({nm, "_fields"},
        {22'd0, op_idx_o, op_strb_o, sp_addr_o}, 0);
  endtask

  task automatic xfer(input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      input logic dn = 1'b0,
                      input logic [31:0] fl = 32'd0);
    logic [4:0]  rg;
    logic        err, st, got;
    logic [31:0] rd;
    logic [3:0]  spa;
    int          exp_waits, waits;
    rg  = a[4:0];
    err = (a[1:0] != 0)
       || !(rg inside {5'h00, 5'h04, 5'h08, 5'h0C, 5'h10})
       || (w && (rg == 5'h0C || rg == 5'h10))
       || (!w && (rg == 5'h04 || rg == 5'h08))
       || (w && busy_m && (rg inside {5'h00, 5'h04, 5'h08}));
    rd = 0;
    st = 0;
    exp_waits = 0;
    if (!err && w) begin
      if (rg == 5'h00) begin
        for (int e = 0; e < 4; e++)
          if (s[e]) ctrl_m[8*e +: 8] = d[8*e +: 8];
        ctrl_m[0] = 1'b0;
        if (s[0] && d[0]) begin
          st = 1;
          busy_m = 1;
          start_q.push_back(1);
        end
      end else if (s != 0) begin
        op_q.push_back('{rg == 5'h08, a[6:5], d, s});
      end
    end else if (!err) begin
      if (rg == 5'h00) rd = ctrl_m;
      else if (rg == 5'h0C) rd = flags_m;
      else begin
        spa = {ctrl_m[5:4], a[6:5]};
        rd = sp_mem[spa];
        exp_waits = 1;
        sp_q.push_back(spa);
      end
    end
    if (dn) begin
      flags_m = fl;
      if (!st) busy_m = 0;
    end
    rsp_q.push_back('{w, err, rd});

    psel_i = 1; penable_i = 0;
    pwrite_i = w; paddr_i = a; pwdata_i = d; pstrb_i = s;
    @(posedge clk); #1;
    penable_i = 1;
    if (dn) begin
      done_i = 1;
      flags_i = fl;
    end
    got = 0;
    waits = 0;
    for (int i = 0; i < 6 && !got; i++) begin
      @(negedge clk);
      if (pready_o) got = 1;
      else waits++;
      @(posedge clk); #1;
      done_i = 0;
    end
    psel_i = 0;
    penable_i = 0;
    if (!got) miss("pready_timeout");
    else chk("wait_states", waits, exp_waits);
    chk("ctrl_o", ctrl_o, ctrl_m);
    chk("busy_o", {31'd0, busy_o}, {31'd0, busy_m});
  endtask

  task automatic pulse_done(input logic [31:0] fl);
    done_i = 1;
    flags_i = fl;
    @(posedge clk); #1;
    done_i = 0;
    flags_m = fl;
    busy_m = 0;
    chk("busy_after_done", {31'd0, busy_o}, 0);
  endtask

  initial begin
    logic [31:0] a, d;
    logic [4:0]  rg;
    logic        w, dn;
    rst_i = 1; psel_i = 0; penable_i = 0; pwrite_i = 0;
    pstrb_i = 0; paddr_i = 0; pwdata_i = 0;
    done_i = 0; flags_i = 0;
    for (int i = 0; i < 16; i++) sp_mem[i] = $urandom;
    sp_mem[7] = 32'hDEADBEEF;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    rst_i = 0;
    xfer(0, 32'h0C, 0, 4'h0);

    xfer(1, 32'h00, 32'h1501, 4'hF);
    chk("ctrl_1500", ctrl_o, 32'h1500);
    pulse_done(32'h5);
    xfer(0, 32'h0C, 0, 4'h0);
    xfer(0, 32'h00, 0, 4'h0);

    xfer(1, 32'h44, 32'h04030201, 4'b0101);
    xfer(1, 32'h28, 32'hA5A5A5A5, 4'b0000);

    xfer(1, 32'h00, 32'h1, 4'h1);
    xfer(1, 32'h08, 32'h11223344, 4'hF);
    xfer(1, 32'h0C, 32'h7, 4'hF);
    xfer(1, 32'h00, 32'h30, 4'hF);
    pulse_done(32'h3);
    xfer(1, 32'h00, 32'h0C01, 4'h3, 1'b1, 32'h9);
    xfer(0, 32'h0C, 0, 4'h0);
    pulse_done(32'hA);

    xfer(1, 32'h00, 32'h10, 4'h1);
    xfer(0, 32'h70, 0, 4'h0);

    xfer(0, 32'h06, 0, 4'h0);
    xfer(0, 32'h14, 0, 4'h0);

    xfer(0, 32'h0C, 0, 4'h0);
    psel_i = 1; penable_i = 0; pwrite_i = 0; paddr_i = 32'h00;
    @(posedge clk); #1;
    rst_i = 1;
    penable_i = 1;
    repeat (2) @(posedge clk);
    #1;
    psel_i = 0;
    penable_i = 0;
    rst_i = 0;
    model_reset();
    chk_idle_outputs("midreset");
    xfer(0, 32'h00, 0, 4'h0);

    for (int n = 0; n < 250; n++) begin
      a = $urandom;
      case ($urandom_range(0, 9))
        0, 9: rg = 5'h00;
        1: rg = 5'h04;
        2: rg = 5'h08;
        3: rg = 5'h0C;
        4: rg = 5'h10;
        5: rg = 5'h14;
        6: rg = 5'h18;
        7: rg = 5'h1C;
        default: rg = {3'($urandom_range(0, 4)), 2'($urandom_range(1, 3))};
      endcase
      a[4:0] = rg;
      w = 1'($urandom);
      if (rg == 5'h10 && $urandom_range(0, 1) == 0) w = 0;
      d = $urandom;
      d[0] = ($urandom_range(0, 2) == 0);
      dn = w && rg == 5'h00 && busy_m && $urandom_range(0, 3) == 0;
      if (busy_m && !dn && $urandom_range(0, 2) == 0)
        pulse_done($urandom);
      xfer(w, a, d, 4'($urandom), dn, $urandom);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("rsp_q_left", rsp_q.size(), 0);
    chk("op_q_left", op_q.size(), 0);
    chk("sp_q_left", sp_q.size(), 0);
    chk("start_q_left", start_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
